// File: rtl/clock_reset_sequencer_if.sv
// Reset-sequencer signal bundle: conditioned reset sources in, ordered resets
// and debug status out.
interface clock_reset_sequencer_if;
  logic       pll_locked;
  logic       external_rstnn;
  logic       sw_reset_req;
  logic       rstnn_periph;
  logic       rstnn_system;
  logic [2:0] seq_state;
  logic       lock_lost;
  logic [7:0] reset_count;

  modport master (
    output pll_locked, external_rstnn, sw_reset_req,
    input  rstnn_periph, rstnn_system, seq_state, lock_lost, reset_count
  );

  modport slave (
    input  pll_locked, external_rstnn, sw_reset_req,
    output rstnn_periph, rstnn_system, seq_state, lock_lost, reset_count
  );
endinterface

// File: rtl/clock_reset_sequencer.sv
// Ordered reset release in the PLL output domain: synchronizes lock and the
// board button, debounces the button, then releases peripherals and, after a
// fixed gap, the system core. Any abort source drops both resets again.
module clock_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int DEBOUNCE_CYCLES    = 16,
  parameter int MIN_ASSERT_CYCLES  = 32,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_GAP        = 8
) (
  input logic                    clk_i,
  input logic                    rst_i,
  clock_reset_sequencer_if.slave bus
);

  localparam logic [2:0] S_ASSERT     = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] S_STABLE     = 3'd2;
  localparam logic [2:0] S_REL_PERIPH = 3'd3;
  localparam logic [2:0] S_RUN        = 3'd4;

  // Counter sized for the longest dwell; terminal values are max-1 so they fit.
  localparam int CMAX_A = (MIN_ASSERT_CYCLES > LOCK_STABLE_CYCLES) ? MIN_ASSERT_CYCLES
                                                                    : LOCK_STABLE_CYCLES;
  localparam int CMAX   = (CMAX_A > RELEASE_GAP) ? CMAX_A : RELEASE_GAP;
  localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int DW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CW-1:0] ASSERT_LAST = CW'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(RELEASE_GAP - 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] lk_sync_q, ex_sync_q;
  logic                   lk_s, ex_s;
  logic                   db_q;
  logic [DW-1:0]          dbc_q;
  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             rc_q, rc_d;
  logic                   ll_q, ll_d;
  logic                   periph_q, system_q;
  logic                   abort;

  // Multi-flop synchronizers for the two asynchronous inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lk_sync_q <= '0;
      ex_sync_q <= '0;
    end else begin
      lk_sync_q <= {lk_sync_q[SYNC_STAGES-2:0], bus.pll_locked};
      ex_sync_q <= {ex_sync_q[SYNC_STAGES-2:0], bus.external_rstnn};
    end
  end

  assign lk_s = lk_sync_q[SYNC_STAGES-1];
  assign ex_s = ex_sync_q[SYNC_STAGES-1];

  // Symmetric debounce: level follows ex_s only after it has differed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      db_q  <= 1'b0;
      dbc_q <= '0;
    end else if (ex_s != db_q) begin
      if (dbc_q == DB_LAST) begin
        db_q  <= ex_s;
        dbc_q <= '0;
      end else begin
        dbc_q <= dbc_q + 1'b1;
      end
    end else begin
      dbc_q <= '0;
    end
  end

  // Sequencer next state; abort outranks every transition outside ASSERT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    ll_d    = ll_q;
    abort   = !db_q || bus.sw_reset_req ||
              (!lk_s && state_q != S_ASSERT && state_q != S_WAIT_LOCK);
    if (state_q != S_ASSERT && abort) begin
      state_d = S_ASSERT;
      cnt_d   = '0;
      if (rc_q != 8'hFF) rc_d = rc_q + 8'd1;
      if (!lk_s && (state_q == S_REL_PERIPH || state_q == S_RUN)) ll_d = 1'b1;
    end else begin
      case (state_q)
        S_ASSERT: begin
          if (bus.sw_reset_req) begin
            cnt_d = '0;
          end else if (cnt_q == ASSERT_LAST) begin
            if (db_q) begin
              state_d = S_WAIT_LOCK;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lk_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end
        end
        S_STABLE: begin
          if (cnt_q == STABLE_LAST) begin
            state_d = S_REL_PERIPH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_REL_PERIPH: begin
          if (cnt_q == GAP_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: ;
        default: begin
          state_d = S_ASSERT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered reset outputs move together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_ASSERT;
      cnt_q    <= '0;
      rc_q     <= '0;
      ll_q     <= 1'b0;
      periph_q <= 1'b0;
      system_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rc_q     <= rc_d;
      ll_q     <= ll_d;
      periph_q <= (state_d == S_REL_PERIPH) || (state_d == S_RUN);
      system_q <= (state_d == S_RUN);
    end
  end

  assign bus.rstnn_periph = periph_q;
  assign bus.rstnn_system = system_q;
  assign bus.seq_state    = state_q;
  assign bus.lock_lost    = ll_q;
  assign bus.reset_count  = rc_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed bench for clock_reset_sequencer with short dwell parameters.
module tb_clock_reset_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nmiss = 0;

  always #5 clk = ~clk;

  clock_reset_sequencer_if bus();

  clock_reset_sequencer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .MIN_ASSERT_CYCLES(4),
    .LOCK_STABLE_CYCLES(8), .RELEASE_GAP(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (bus.seq_state !== s && n < 200) begin
      tick;
      n++;
    end
    chk(tag, bus.seq_state, s);
  endtask

  task automatic periph_rise(output int n);
    n = 0;
    while (bus.rstnn_periph !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.pll_locked = 1'b1;
    bus.external_rstnn = 1'b1;
    bus.sw_reset_req = 1'b0;
    tick;
    tick;
    chk("rst_state", bus.seq_state, 0);
    chk("rst_periph", bus.rstnn_periph, 0);
    chk("rst_system", bus.rstnn_system, 0);
    chk("rst_lock_lost", bus.lock_lost, 0);
    chk("rst_count", bus.reset_count, 0);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    int seen;
    int tmo;
    bus.pll_locked = 1'b1;
    bus.external_rstnn = 1'b1;
    bus.sw_reset_req = 1'b0;

    // 1: nominal release
    do_reset;
    wait_state(3'd1, "t1_wait_lock");
    chk("t1_periph_low_wl", bus.rstnn_periph, 0);
    wait_state(3'd2, "t1_stable");
    periph_rise(n);
    chk("t1_periph_delay", n, 8);
    chk("t1_state_rel", bus.seq_state, 3);
    chk("t1_system_low", bus.rstnn_system, 0);
    n = 0;
    while (bus.rstnn_system !== 1'b1 && n < 50) begin tick; n++; end
    chk("t1_system_gap", n, 2);
    chk("t1_state_run", bus.seq_state, 4);
    chk("t1_count", bus.reset_count, 0);
    chk("t1_lock_lost", bus.lock_lost, 0);

    // 2: one-cycle lock glitch at STABLE cnt=5
    do_reset;
    wait_state(3'd2, "t2_stable");
    repeat (5) tick;
    bus.pll_locked = 1'b0;
    tick;
    bus.pll_locked = 1'b1;
    seen = 0;
    n = 0;
    while (bus.seq_state !== 3'd0 && n < 20) begin
      tick;
      n++;
      if (bus.rstnn_periph !== 1'b0 || bus.rstnn_system !== 1'b0) seen = 1;
    end
    chk("t2_abort_state", bus.seq_state, 0);
    chk("t2_no_release", seen, 0);
    chk("t2_count", bus.reset_count, 1);
    wait_state(3'd2, "t2_stable_again");
    periph_rise(n);
    chk("t2_full_recount", n, 8);
    chk("t2_lock_lost", bus.lock_lost, 0);

    // 3: lock loss in RUN, sticky lock_lost
    do_reset;
    wait_state(3'd4, "t3_run");
    bus.pll_locked = 1'b0;
    n = 0;
    while (bus.rstnn_periph !== 1'b0 && n < 20) begin tick; n++; end
    chk("t3_drop_latency", n, 3);
    chk("t3_system_low", bus.rstnn_system, 0);
    chk("t3_lock_lost", bus.lock_lost, 1);
    chk("t3_count", bus.reset_count, 1);
    bus.pll_locked = 1'b1;
    wait_state(3'd4, "t3_rerun");
    chk("t3_periph_rerun", bus.rstnn_periph, 1);
    chk("t3_lock_lost_sticky", bus.lock_lost, 1);
    chk("t3_count_after", bus.reset_count, 1);

    // 4: button bounce filtered, real press aborts
    do_reset;
    wait_state(3'd4, "t4_run");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.external_rstnn = ((i / 2) % 2) == 1;
      tick;
      if (bus.rstnn_periph !== 1'b1 || bus.rstnn_system !== 1'b1) bad++;
    end
    bus.external_rstnn = 1'b1;
    repeat (6) tick;
    chk("t4_bounce_glitches", bad, 0);
    chk("t4_still_run", bus.seq_state, 4);
    chk("t4_count_bounce", bus.reset_count, 0);
    bus.external_rstnn = 1'b0;
    repeat (6) tick;
    bus.external_rstnn = 1'b1;
    wait_state(3'd0, "t4_press_abort");
    chk("t4_periph_low", bus.rstnn_periph, 0);
    chk("t4_count_press", bus.reset_count, 1);
    wait_state(3'd4, "t4_rerun");

    // 5: software reset in RUN and in ASSERT
    do_reset;
    wait_state(3'd4, "t5_run");
    bus.sw_reset_req = 1'b1;
    tick;
    bus.sw_reset_req = 1'b0;
    chk("t5_periph_low", bus.rstnn_periph, 0);
    chk("t5_system_low", bus.rstnn_system, 0);
    chk("t5_state", bus.seq_state, 0);
    chk("t5_count", bus.reset_count, 1);
    wait_state(3'd2, "t5_stable");
    periph_rise(n);
    chk("t5_periph_delay", n, 8);
    wait_state(3'd4, "t5_rerun");
    bus.sw_reset_req = 1'b1;
    tick;
    bus.sw_reset_req = 1'b0;
    chk("t5_count2", bus.reset_count, 2);
    repeat (3) tick;
    chk("t5_assert_cnt3", bus.seq_state, 0);
    bus.sw_reset_req = 1'b1;
    tick;
    bus.sw_reset_req = 1'b0;
    n = 0;
    while (bus.seq_state !== 3'd1 && n < 20) begin tick; n++; end
    chk("t5_dwell_restart", n, 4);
    chk("t5_count_unchanged", bus.reset_count, 2);

    // 6: reset_count saturation, then rst mid-sequence
    do_reset;
    bus.pll_locked = 1'b0;
    tmo = 0;
    for (int i = 0; i < 260; i++) begin
      n = 0;
      while (bus.seq_state !== 3'd1 && n < 50) begin tick; n++; end
      if (n >= 50) tmo++;
      bus.sw_reset_req = 1'b1;
      tick;
      bus.sw_reset_req = 1'b0;
      if (i == 253) chk("t6_count_254", bus.reset_count, 254);
      if (i == 254) chk("t6_count_255", bus.reset_count, 255);
    end
    chk("t6_timeouts", tmo, 0);
    chk("t6_count_sat", bus.reset_count, 255);
    chk("t6_lock_lost", bus.lock_lost, 0);
    bus.pll_locked = 1'b1;
    wait_state(3'd3, "t6_rel_periph");
    chk("t6_periph_high", bus.rstnn_periph, 1);
    rst = 1'b1;
    tick;
    chk("t6_rst_state", bus.seq_state, 0);
    chk("t6_rst_periph", bus.rstnn_periph, 0);
    chk("t6_rst_system", bus.rstnn_system, 0);
    chk("t6_rst_count", bus.reset_count, 0);
    chk("t6_rst_lock_lost", bus.lock_lost, 0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end
endmodule
